// File: rtl/voter_pkg.sv
// Shared types and helpers for the threshold voter: filter state encoding,
// channel popcount and the derived count/threshold width.
package voter_pkg;

   localparam int MAX_N = 64;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } filt_state_e;

   // Width needed to hold a count of 0..n inclusive.
   function automatic int cw_of(input int n);
      return $clog2(n + 1);
   endfunction

   // Counts set bits among the lowest n bits of v.
   function automatic logic [6:0] popcount(input logic [63:0] v, input int n);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < n) c = c + 7'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/vote_filter.sv
// Persistence filter: the committed vote only follows the raw decision after
// it has disagreed for HOLD consecutive enabled cycles.
module vote_filter
   import voter_pkg::*;
#(
   parameter  int HOLD = 2,
   localparam int HW   = $clog2(HOLD + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic raw,
   output logic vote,
   output logic changed
);

   filt_state_e   state, state_d;
   logic [HW-1:0] hold_cnt, hold_d;
   logic          vote_d, changed_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= STABLE;
         hold_cnt <= '0;
         vote     <= 1'b0;
         changed  <= 1'b0;
      end else begin
         state    <= state_d;
         hold_cnt <= hold_d;
         vote     <= vote_d;
         changed  <= changed_d;
      end
   end

   // Frozen when en is low except that changed always drops back to 0.
   always_comb begin
      state_d   = state;
      hold_d    = hold_cnt;
      vote_d    = vote;
      changed_d = 1'b0;
      if (en) begin
         case (state)
            STABLE: begin
               if (raw != vote) begin
                  if (HOLD == 1) begin
                     vote_d    = raw;
                     changed_d = 1'b1;
                  end else begin
                     state_d = PENDING;
                     hold_d  = HW'(1);
                  end
               end else begin
                  hold_d = '0;
               end
            end
            PENDING: begin
               if (raw == vote) begin
                  state_d = STABLE;
                  hold_d  = '0;
               end else if (hold_cnt == HW'(HOLD - 1)) begin
                  vote_d    = raw;
                  changed_d = 1'b1;
                  state_d   = STABLE;
                  hold_d    = '0;
               end else begin
                  hold_d = hold_cnt + HW'(1);
               end
            end
            default: begin
               state_d = STABLE;
               hold_d  = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/threshold_voter.sv
// N-channel registered threshold voter: samples masked channel votes, compares
// the count with a run-time threshold and debounces the result.
module threshold_voter
   import voter_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int HOLD = 2,
   localparam int CW   = cw_of(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [N-1:0]  ch_in,
   input  logic [N-1:0]  ch_mask,
   input  logic [CW-1:0] thr,
   output logic          vote,
   output logic [CW-1:0] count,
   output logic          changed,
   output logic          split
);

   logic [CW-1:0] count_q, act_q, thr_q;
   logic          raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         act_q   <= '0;
         thr_q   <= '0;
      end else if (en) begin
         count_q <= CW'(popcount(64'(ch_in & ch_mask), N));
         act_q   <= CW'(popcount(64'(ch_mask), N));
         thr_q   <= thr;
      end
   end

   // A zero threshold disables the vote rather than making it trivially true.
   assign raw   = (thr_q != '0) && (count_q >= thr_q);
   assign split = (count_q != '0) && (count_q != act_q);
   assign count = count_q;

   vote_filter #(
      .HOLD(HOLD)
   ) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .raw    (raw),
      .vote   (vote),
      .changed(changed)
   );

endmodule

// File: tb/tb_threshold_voter.sv
// Bench for threshold_voter: three instances (N=4/HOLD=1, N=4/HOLD=3,
// N=9/HOLD=2) checked each cycle against a sample-history reference model.
module tb_threshold_voter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] ch4, mask4;
   logic [2:0] thr4;
   logic [8:0] ch9, mask9;
   logic [3:0] thr9;

   logic       vote_h1, changed_h1, split_h1;
   logic [2:0] count_h1;
   logic       vote_h3, changed_h3, split_h3;
   logic [2:0] count_h3;
   logic       vote_n9, changed_n9, split_n9;
   logic [3:0] count_n9;

   int total = 0;
   int bad   = 0;

   // Reference model: per instance, the last sampled count/active/threshold and
   // how many consecutive enabled samples have disagreed with the vote.
   int hold_of[3] = '{1, 3, 2};
   int m_cnt[3], m_act[3], m_thr[3], m_vote[3], m_chg[3], m_run[3];

   threshold_voter #(.N(4), .HOLD(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_in(ch4), .ch_mask(mask4), .thr(thr4),
      .vote(vote_h1), .count(count_h1), .changed(changed_h1), .split(split_h1));

   threshold_voter #(.N(4), .HOLD(3)) u_h3 (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_in(ch4), .ch_mask(mask4), .thr(thr4),
      .vote(vote_h3), .count(count_h3), .changed(changed_h3), .split(split_h3));

   threshold_voter #(.N(9), .HOLD(2)) u_n9 (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_in(ch9), .ch_mask(mask9), .thr(thr9),
      .vote(vote_n9), .count(count_n9), .changed(changed_n9), .split(split_n9));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_act[i] = 0; m_thr[i] = 0;
         m_vote[i] = 0; m_chg[i] = 0; m_run[i] = 0;
      end
   endtask

   task automatic model_edge();
      logic [63:0] c, m;
      int t;
      bit raw;
      for (int i = 0; i < 3; i++) begin
         c = (i == 2) ? 64'(ch9) : 64'(ch4);
         m = (i == 2) ? 64'(mask9) : 64'(mask4);
         t = (i == 2) ? int'(thr9) : int'(thr4);
         m_chg[i] = 0;
         if (en) begin
            raw = (m_thr[i] != 0) && (m_cnt[i] >= m_thr[i]);
            if (int'(raw) != m_vote[i]) begin
               m_run[i]++;
               if (m_run[i] == hold_of[i]) begin
                  m_vote[i] = int'(raw);
                  m_chg[i]  = 1;
                  m_run[i]  = 0;
               end
            end else begin
               m_run[i] = 0;
            end
            m_cnt[i] = $countones(c & m);
            m_act[i] = $countones(m);
            m_thr[i] = t;
         end
      end
   endtask

   task automatic chk_inst(input int i, input logic v, input logic [3:0] cnt,
                           input logic chg, input logic sp);
      chk($sformatf("vote[%0d]", i), 32'(v), m_vote[i]);
      chk($sformatf("count[%0d]", i), 32'(cnt), m_cnt[i]);
      chk($sformatf("changed[%0d]", i), 32'(chg), m_chg[i]);
      chk($sformatf("split[%0d]", i), 32'(sp),
          32'((m_cnt[i] != 0) && (m_cnt[i] != m_act[i])));
   endtask

   task automatic check_all();
      chk_inst(0, vote_h1, 4'(count_h1), changed_h1, split_h1);
      chk_inst(1, vote_h3, 4'(count_h3), changed_h3, split_h3);
      chk_inst(2, vote_n9, count_n9, changed_n9, split_n9);
   endtask

   // driver: advance n enabled/disabled edges, update model, check after edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         check_all();
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0;
      ch4 = '0; mask4 = '0; thr4 = '0;
      ch9 = '0; mask9 = '0; thr9 = '0;
      model_reset();
      #12;
      check_all();
      #2 rst_n = 1'b1;

      // legacy 3-of-4 sweep on the HOLD=1 instance
      en = 1'b1; mask4 = 4'hF; thr4 = 3'd3;
      for (int v = 0; v < 16; v++) begin
         ch4 = 4'(v);
         step(3);
         chk("legacy_vote", 32'(vote_h1), 32'($countones(4'(v)) >= 3));
         chk("legacy_count", 32'(count_h1), 32'($countones(4'(v))));
      end

      // glitch rejection on HOLD=3
      ch4 = 4'b0000; step(5);
      ch4 = 4'b1110; step(2);
      ch4 = 4'b0000; step(4);
      chk("glitch_vote", 32'(vote_h3), 32'd0);
      ch4 = 4'b1110; step(4);
      chk("glitch_commit", 32'(vote_h3), 32'd1);

      // masking and threshold
      mask4 = 4'b0011; ch4 = 4'b1101; thr4 = 3'd1; step(5);
      chk("mask_count", 32'(count_h3), 32'd1);
      chk("mask_split", 32'(split_h3), 32'd1);
      chk("mask_vote", 32'(vote_h3), 32'd1);
      thr4 = 3'd0; step(5);
      chk("thr0_vote", 32'(vote_h3), 32'd0);
      thr4 = 3'd3; ch4 = 4'b1111; step(5);
      chk("thr_over_act", 32'(vote_h3), 32'd0);

      // enable freeze mid-PENDING
      mask4 = 4'hF; thr4 = 3'd3; ch4 = 4'b0000; step(5);
      ch4 = 4'b1111; step(2);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         ch4 = 4'($urandom_range(0, 15));
         step(1);
      end
      chk("freeze_vote", 32'(vote_h3), 32'd0);
      en = 1'b1; ch4 = 4'b1111; step(3);
      chk("resume_vote", 32'(vote_h3), 32'd1);

      // async reset while HOLD=3 instance is pending a fall
      ch4 = 4'b0000; step(2);
      #3 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(posedge clk); #1;
      check_all();
      #3 rst_n = 1'b1;
      step(2);

      // width generality on N=9
      mask9 = 9'h1FF; thr9 = 4'd5; ch9 = 9'b1_1111_0000; step(4);
      chk("n9_count5", 32'(count_n9), 32'd5);
      chk("n9_vote", 32'(vote_n9), 32'd1);
      ch9 = 9'h1FF; step(2);
      chk("n9_count9", 32'(count_n9), 32'd9);
      chk("n9_split", 32'(split_n9), 32'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         en    = ($urandom_range(0, 7) != 0);
         ch4   = 4'($urandom_range(0, 15));
         mask4 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         thr4  = 3'($urandom_range(0, 7));
         ch9   = 9'($urandom_range(0, 511));
         mask9 = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'h1FF;
         thr9  = 4'($urandom_range(0, 10));
         step(($urandom_range(0, 3) == 0) ? 3 : 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
